// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
// State encoding and step-counter width live here so the top and any future users agree.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit full adder, purely combinational, zero latency; no handshake.
// It is the only arithmetic element of the serial adder.
module fa_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder_param.sv
// Bit-serial add/sub over WIDTH cycles, LSB first; o_done exactly WIDTH edges after accept.
// Backpressure: o_ready only in IDLE, i_start ignored otherwise; results held until next completion.
module serial_adder_param
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  fa_bit_cell u_fa (
    .i_a  (a_sh_q[0]),
    .i_b  (b_sh_q[0]),
    .i_c  (carry_q),
    .o_s  (fa_s),
    .o_co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          // Subtraction is A + ~B + 1: invert B up front and seed the carry with 1.
          a_sh_d  = i_a;
          b_sh_d  = i_sub ? ~i_b : i_b;
          carry_d = i_sub ? 1'b1 : i_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB, needed for signed overflow.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule
